pipelined_loa_adder: RTL and testbench
======================================

Name: pipelined_loa_adder

Overview:
- Parametrised successor to the combinational ripple-carry adder. Lower-part-OR approximate adder (LOA) with a configurable number of approximate LSBs.
- Exact upper part is a ripple-carry chain cut into STAGES registered segments.
- valid/ready handshake on both sides.
- Sits in the approximate-arithmetic datapath ahead of accumulators and multipliers; also acts as a bench target for error characterisation.

Parameters:
- WIDTH, 16, operand width in bits; WIDTH % STAGES == 0 required.
- LOWER, 4, number of approximate LSBs (0..WIDTH); 0 gives an exact adder.
- STAGES, 2, pipeline segments and latency in cycles (1..4); segment width SEG = WIDTH/STAGES.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_ni  input  1  reset, synchronous, active-low.
- valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands this cycle.
- add1_i  input  WIDTH  operand A.
- add2_i  input  WIDTH  operand B.
- carry_i  input  1  carry-in; used only when LOWER==0, ignored otherwise.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- result_o  output  WIDTH+1  {carry-out, sum}.

Behaviour:
- Single clock. Reset is synchronous and active-low on rst_ni, sampled at the rising edge of clk_i.
- Reset clears all stage valid bits: valid_o=0, result_o=0, ready_o=1 in the first cycle after reset.
- Reset mid-operation discards all in-flight items; no partial result is ever emitted.
- Arithmetic, bit i < LOWER: sum[i] = A[i] | B[i].
- Carry into bit LOWER = A[LOWER-1] & B[LOWER-1] when LOWER > 0; carry_i when LOWER == 0.
- Bits LOWER..WIDTH-1: exact ripple-carry add; result_o[WIDTH] = final carry-out.
- LOWER == WIDTH: result = {A[WIDTH-1]&B[WIDTH-1], A|B}.
- Pipelining: stage s (0..STAGES-1) computes bits [s*SEG, (s+1)*SEG) using the carry registered from stage s-1.
  - Each stage registers its partial sum, carry-out, a valid bit, and skewed copies of the not-yet-consumed operand bits.
  - The LOA lower field is computed in whichever stage(s) own those bits; the approximate carry enters the exact chain at bit LOWER even when LOWER is mid-segment.
  - Stage 0 registers from the inputs; the last stage drives result_o.
- Latency: exactly STAGES cycles from an accepted input (valid_i & ready_o) to valid_o, absent backpressure.
- Throughput: one result per cycle.
- Handshake: stage s advances when its register is empty or stage s+1 accepts; last stage advances on ready_i.
  - ready_o = stage-0 advance condition. It is combinational from ready_i through the stage valids (no skid buffer).
- valid_o and result_o are held stable while valid_o & ~ready_i.
- Full pipeline with ready_i=0 gives ready_o=0; any valid_i is ignored while ready_o=0.
- Simultaneous accept and emit in one cycle is allowed; occupancy is unchanged.
- Bubbles (valid_i=0) propagate as empty stages. Downstream stages keep draining while upstream stages are empty.

Optional Feature:
- Macro LOA_ERROR_METRIC_EN.
- When defined, adds three outputs and associated logic:
  - exact_o (WIDTH+1): exact A+B+carry_i, pipelined alongside result_o with identical latency and stall behaviour.
  - err_o (signed, WIDTH+2): exact_o - result_o.
  - err_cnt_o (16): count of emitted results with err_o != 0. It increments on valid_o & ready_i, saturates at 0xFFFF, and clears on reset.
- When not defined, these ports and all their logic are absent; the port list is exactly as above.

Test Plan:
- WIDTH=16, LOWER=4, STAGES=2: A=0x00FF, B=0x0001 -> result_o=0x000FF two cycles later. With the macro: exact_o=0x00100, err_o=+1, err_cnt_o=1.
- Same config: A=0x1238, B=0x0008 -> result_o=0x01248, exact_o=0x01240, err_o=-8.
- LOWER=0: A=0xFFFF, B=0x0001, carry_i=1 -> result_o=0x10001, err_o=0.
- Streaming: 8 back-to-back inputs with ready_i=1 -> 8 results on consecutive cycles, in order, first at cycle 2.
- Backpressure: ready_i=0 for 5 cycles mid-stream -> ready_o drops once 2 items are held; result_o stable; no loss or duplication after release.
- Reset mid-stream (rst_ni=0 with 2 items in flight) -> valid_o=0 the next cycle; no stale results after rst_ni=1; err_cnt_o=0.

Source files
------------

// File: rtl/pipelined_loa_adder.sv
// Pipelined lower-part-OR approximate adder with valid/ready handshake on both sides.
// Define LOA_ERROR_METRIC_EN to add exact_o, err_o and err_cnt_o error-tracking outputs.
module pipelined_loa_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned LOWER  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   add1_i,
    input  logic [WIDTH-1:0]   add2_i,
    input  logic               carry_i,
    output logic               valid_o,
    input  logic               ready_i,
`ifdef LOA_ERROR_METRIC_EN
    output logic [WIDTH:0]          exact_o,
    output logic signed [WIDTH+1:0] err_o,
    output logic [15:0]             err_cnt_o,
`endif
    output logic [WIDTH:0]     result_o
);

    localparam int unsigned SEG  = WIDTH / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per-stage registers: valid, partial sum, carry-out and skewed operand copies
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];

    // Stage inputs: primary ports for stage 0, previous stage registers otherwise
    logic             stg_valid_c [STAGES];
    logic             stg_carry_c [STAGES];
    logic [WIDTH-1:0] stg_sum_c   [STAGES];
    logic [WIDTH-1:0] stg_a_c     [STAGES];
    logic [WIDTH-1:0] stg_b_c     [STAGES];
    logic             adv_c       [STAGES];

    // Stage s may load when it is empty or its content moves on this cycle
    always_comb begin : advance
        for (int unsigned s = 0; s < STAGES; s++) begin
            adv_c[s] = 1'b0;
        end
        adv_c[LAST] = ~valid_q[LAST] | ready_i;
        for (int s = int'(STAGES) - 2; s >= 0; s--) begin
            adv_c[s] = ~valid_q[s] | adv_c[s+1];
        end
    end

    always_comb begin : stage_inputs
        stg_valid_c[0] = valid_i;
        stg_a_c[0]     = add1_i;
        stg_b_c[0]     = add2_i;
        stg_sum_c[0]   = '0;
        stg_carry_c[0] = (LOWER == 0) ? carry_i : 1'b0;
        for (int unsigned s = 1; s < STAGES; s++) begin
            stg_valid_c[s] = valid_q[s-1];
            stg_a_c[s]     = a_q[s-1];
            stg_b_c[s]     = b_q[s-1];
            stg_sum_c[s]   = sum_q[s-1];
            stg_carry_c[s] = carry_q[s-1];
        end
    end

    // Each stage fills its own segment; bits below LOWER are OR-approximated
    always_comb begin : stage_next
        logic             c;
        logic             ai;
        logic             bi;
        logic [WIDTH-1:0] acc;
        int unsigned      i;
        for (int unsigned s = 0; s < STAGES; s++) begin
            valid_d[s] = valid_q[s];
            carry_d[s] = carry_q[s];
            sum_d[s]   = sum_q[s];
            a_d[s]     = a_q[s];
            b_d[s]     = b_q[s];
            c   = stg_carry_c[s];
            acc = stg_sum_c[s];
            for (int unsigned k = 0; k < SEG; k++) begin
                i  = s * SEG + k;
                ai = stg_a_c[s][i];
                bi = stg_b_c[s][i];
                if (i < LOWER) begin
                    acc[i] = ai | bi;
                    c      = (i == LOWER - 1) ? (ai & bi) : 1'b0;
                end else begin
                    acc[i] = ai ^ bi ^ c;
                    c      = (ai & bi) | (c & (ai ^ bi));
                end
            end
            if (adv_c[s]) begin
                valid_d[s] = stg_valid_c[s];
                carry_d[s] = c;
                sum_d[s]   = acc;
                a_d[s]     = stg_a_c[s];
                b_d[s]     = stg_b_c[s];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                valid_q[s] <= 1'b0;
                carry_q[s] <= 1'b0;
                sum_q[s]   <= '0;
                a_q[s]     <= '0;
                b_q[s]     <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                valid_q[s] <= valid_d[s];
                carry_q[s] <= carry_d[s];
                sum_q[s]   <= sum_d[s];
                a_q[s]     <= a_d[s];
                b_q[s]     <= b_d[s];
            end
        end
    end

    assign ready_o  = adv_c[0];
    assign valid_o  = valid_q[LAST];
    assign result_o = {carry_q[LAST], sum_q[LAST]};

`ifdef LOA_ERROR_METRIC_EN
    // Exact reference sum travels in lockstep with the approximate pipeline
    logic [WIDTH:0] exact_q [STAGES];
    logic [WIDTH:0] exact_d [STAGES];
    logic [15:0]    err_cnt_q;
    logic [15:0]    err_cnt_d;

    always_comb begin : exact_next
        for (int unsigned s = 0; s < STAGES; s++) begin
            exact_d[s] = exact_q[s];
        end
        if (adv_c[0]) begin
            exact_d[0] = (WIDTH+1)'(add1_i) + (WIDTH+1)'(add2_i) + (WIDTH+1)'(carry_i);
        end
        for (int unsigned s = 1; s < STAGES; s++) begin
            if (adv_c[s]) begin
                exact_d[s] = exact_q[s-1];
            end
        end
    end

    always_comb begin : err_cnt_next
        err_cnt_d = err_cnt_q;
        if (valid_o && ready_i && (err_o != '0) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                exact_q[s] <= '0;
            end
            err_cnt_q <= '0;
        end else begin
            for (int unsigned s = 0; s < STAGES; s++) begin
                exact_q[s] <= exact_d[s];
            end
            err_cnt_q <= err_cnt_d;
        end
    end

    assign exact_o   = exact_q[LAST];
    assign err_o     = $signed({1'b0, exact_o}) - $signed({1'b0, result_o});
    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_pipelined_loa_adder.sv
// Randomised scoreboard bench for pipelined_loa_adder: LOWER=4/STAGES=2 and LOWER=0/STAGES=4 instances.
// Error-metric outputs are checked when LOA_ERROR_METRIC_EN is defined.
module tb_pipelined_loa_adder;

    localparam int S1 = 2;
    localparam int S2 = 4;

    typedef struct {
        logic [16:0] res;
        logic [16:0] ex;
        int          t;
    } item_t;

    logic        clk;
    logic        rst_ni;
    logic        v1, r1, c1, v2, r2, c2;
    logic [15:0] a1, b1, a2, b2;
    logic        ready_o1, valid_o1, ready_o2, valid_o2;
    logic [16:0] result_o1, result_o2;
`ifdef LOA_ERROR_METRIC_EN
    logic [16:0]        exact_o1, exact_o2;
    logic signed [17:0] err_o1, err_o2;
    logic [15:0]        err_cnt_o1, err_cnt_o2;
`endif

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    ecnt     = 0;
    bit    lat_chk  = 0;
    bit    hold1    = 0;
    logic [16:0] held_res;
    item_t q1[$];
    item_t q2[$];

    pipelined_loa_adder #(.WIDTH(16), .LOWER(4), .STAGES(S1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(v1), .ready_o(ready_o1),
        .add1_i(a1), .add2_i(b1), .carry_i(c1), .valid_o(valid_o1), .ready_i(r1),
`ifdef LOA_ERROR_METRIC_EN
        .exact_o(exact_o1), .err_o(err_o1), .err_cnt_o(err_cnt_o1),
`endif
        .result_o(result_o1)
    );

    pipelined_loa_adder #(.WIDTH(16), .LOWER(0), .STAGES(S2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(v2), .ready_o(ready_o2),
        .add1_i(a2), .add2_i(b2), .carry_i(c2), .valid_o(valid_o2), .ready_i(r2),
`ifdef LOA_ERROR_METRIC_EN
        .exact_o(exact_o2), .err_o(err_o2), .err_cnt_o(err_cnt_o2),
`endif
        .result_o(result_o2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference: low field is A|B, upper field is an ordinary sum of shifted operands
    function automatic logic [16:0] loa_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input int lower);
        logic [16:0] mask, up;
        logic        c;
        if (lower == 0) return 17'(a) + 17'(b) + 17'(cin);
        mask = (17'(1) << lower) - 17'(1);
        c    = a[lower-1] & b[lower-1];
        up   = (17'(a) >> lower) + (17'(b) >> lower) + 17'(c);
        return (up << lower) | (17'(a | b) & mask);
    endfunction

    // One clock: settle, score outputs and accepts, then wait for the next falling edge
    task automatic step();
        item_t it;
        #1;
        if (!rst_ni) begin
            q1.delete();
            q2.delete();
            ecnt  = 0;
            hold1 = 0;
        end else begin
            check("ready1", 64'(ready_o1), 64'((q1.size() < S1) || r1));
            check("ready2", 64'(ready_o2), 64'((q2.size() < S2) || r2));
            if (hold1) begin
                check("hold_valid", 64'(valid_o1), 64'(1));
                check("hold_result", 64'(result_o1), 64'(held_res));
            end
`ifdef LOA_ERROR_METRIC_EN
            check("err_cnt", 64'(err_cnt_o1), 64'(ecnt));
`endif
            if (valid_o1 && r1) begin
                if (q1.size() == 0) begin
                    check("spurious1", 64'(valid_o1), 64'(0));
                end else begin
                    it = q1.pop_front();
                    check("result1", 64'(result_o1), 64'(it.res));
                    if (lat_chk) check("latency1", 64'(cyc - it.t), 64'(S1));
`ifdef LOA_ERROR_METRIC_EN
                    check("exact1", 64'(exact_o1), 64'(it.ex));
                    check("err1", 64'($unsigned(err_o1)), 64'(18'(18'(it.ex) - 18'(it.res))));
`endif
                    if (it.ex != it.res && ecnt < 65535) ecnt++;
                end
            end
            if (valid_o2 && r2) begin
                if (q2.size() == 0) begin
                    check("spurious2", 64'(valid_o2), 64'(0));
                end else begin
                    it = q2.pop_front();
                    check("result2", 64'(result_o2), 64'(it.res));
                    if (lat_chk) check("latency2", 64'(cyc - it.t), 64'(S2));
                end
            end
            hold1    = valid_o1 && !r1;
            held_res = result_o1;
            if (v1 && ready_o1) q1.push_back('{loa_ref(a1, b1, c1, 4), 17'(a1) + 17'(b1) + 17'(c1), cyc});
            if (v2 && ready_o2) q2.push_back('{loa_ref(a2, b2, c2, 0), 17'(a2) + 17'(b2) + 17'(c2), cyc});
        end
        @(negedge clk);
        cyc++;
    endtask

    function automatic logic [15:0] rnd16();
        logic [15:0] x;
        x = 16'($urandom);
        case ($urandom_range(0, 7))
            0: x = 16'hFFFF;
            1: x = 16'h0000;
            default: ;
        endcase
        return x;
    endfunction

    task automatic rand_in(input bit bp);
        v1 = 1'($urandom_range(0, 3) != 0);
        a1 = rnd16(); b1 = rnd16(); c1 = 1'($urandom);
        v2 = 1'($urandom_range(0, 3) != 0);
        a2 = rnd16(); b2 = rnd16(); c2 = 1'($urandom);
        r1 = bp ? 1'($urandom_range(0, 2) != 0) : 1'b1;
        r2 = bp ? 1'($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        {v1, c1, v2, c2} = '0;
        {r1, r2} = 2'b11;
        {a1, b1, a2, b2} = '0;
        step();
        step();
        rst_ni = 1'b1;
        #1;
        check("rst_valid", 64'(valid_o1), 64'(0));
        check("rst_result", 64'(result_o1), 64'(0));
        check("rst_ready", 64'(ready_o1), 64'(1));
        check("rst_valid2", 64'(valid_o2), 64'(0));

        // Directed vectors from the worked examples
        lat_chk = 1;
        v1 = 1; a1 = 16'h00FF; b1 = 16'h0001; c1 = 0;
        v2 = 1; a2 = 16'hFFFF; b2 = 16'h0001; c2 = 1;
        step();
        v2 = 0;
        a1 = 16'h1238; b1 = 16'h0008;
        step();
        v1 = 0;
        repeat (6) step();

        // Back-to-back stream, no backpressure
        repeat (8) begin
            v1 = 1; a1 = rnd16(); b1 = rnd16(); c1 = 1'($urandom);
            v2 = 1; a2 = rnd16(); b2 = rnd16(); c2 = 1'($urandom);
            step();
        end
        {v1, v2} = 2'b00;
        repeat (6) step();

        // Five cycles of backpressure mid-stream
        lat_chk = 0;
        repeat (3) begin v1 = 1; a1 = rnd16(); b1 = rnd16(); step(); end
        r1 = 0;
        repeat (5) begin a1 = rnd16(); b1 = rnd16(); step(); end
        r1 = 1;
        repeat (4) begin a1 = rnd16(); b1 = rnd16(); step(); end
        v1 = 0;
        repeat (4) step();

        // Random traffic with random backpressure
        repeat (400) begin rand_in(1); step(); end

        // Reset with items in flight
        {r1, r2} = 2'b11;
        {v1, v2} = 2'b11;
        repeat (2) begin a1 = rnd16(); b1 = rnd16(); a2 = rnd16(); b2 = rnd16(); step(); end
        {v1, v2} = 2'b00;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        check("midrst_valid1", 64'(valid_o1), 64'(0));
        check("midrst_valid2", 64'(valid_o2), 64'(0));
`ifdef LOA_ERROR_METRIC_EN
        check("midrst_errcnt", 64'(err_cnt_o1), 64'(0));
`endif
        repeat (6) step();
        repeat (40) begin rand_in(1); step(); end

        // Drain with a bounded cycle budget
        {v1, v2} = 2'b00;
        {r1, r2} = 2'b11;
        repeat (10) step();
        check("drain1", 64'(q1.size()), 64'(0));
        check("drain2", 64'(q2.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
